// File: rtl/dot_product_sequencer.sv
// Signed dot-product sequencer: accepts (a, b) pairs over a valid/ready handshake,
// multiplies each pair and accumulates through a ripple-carry adder with sticky overflow.

module carry_ripple_adder #(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] carry;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = carry_in;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow = carry[BIT_WIDTH] ^ carry[BIT_WIDTH-1];

endmodule

module dot_product_sequencer #(
    parameter int BIT_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a_in,
    input  logic [BIT_WIDTH-1:0] b_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 overflow,
    output logic                 negative
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   count;
    logic [BIT_WIDTH-1:0]   product;
    logic                   product_valid;

    logic signed [2*BIT_WIDTH-1:0] a_ext;
    logic signed [2*BIT_WIDTH-1:0] b_ext;
    logic signed [2*BIT_WIDTH-1:0] full_product;
    logic                          mul_overflow;
    logic [BIT_WIDTH-1:0]          acc_sum;
    logic                          acc_overflow;
    logic                          accept;
    logic                          last_pair;

    assign a_ext        = {{BIT_WIDTH{a_in[BIT_WIDTH-1]}}, a_in};
    assign b_ext        = {{BIT_WIDTH{b_in[BIT_WIDTH-1]}}, b_in};
    assign full_product = a_ext * b_ext;

    // The product fits only if its upper half is a pure sign extension of the lower half.
    assign mul_overflow = full_product !=
                          {{BIT_WIDTH{full_product[BIT_WIDTH-1]}}, full_product[BIT_WIDTH-1:0]};

    assign accept    = in_valid & in_ready;
    assign last_pair = (count == LEN_WIDTH'(1));
    assign negative  = result[BIT_WIDTH-1];

    carry_ripple_adder #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_adder (
        .a        (result),
        .b        (product),
        .carry_in (1'b0),
        .sum      (acc_sum),
        .overflow (acc_overflow)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            overflow      <= 1'b0;
            count         <= '0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            done <= 1'b0;

            // The accumulate stage trails the multiply stage by one edge.
            if (product_valid) begin
                result <= acc_sum;
                if (acc_overflow) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        count         <= length;
                        result        <= '0;
                        overflow      <= 1'b0;
                        product_valid <= 1'b0;
                        busy          <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end

                ACCEPT: begin
                    product_valid <= accept;
                    if (accept) begin
                        product <= full_product[BIT_WIDTH-1:0];
                        count   <= count - 1'b1;
                        if (mul_overflow) begin
                            overflow <= 1'b1;
                        end
                        if (last_pair) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    product_valid <= 1'b0;
                    state         <= DONE;
                    done          <= 1'b1;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: a 32-bit and an 8-bit instance run in lockstep on the
// same stimulus, checked against fixed vectors and an arithmetic reference model.

module tb_dot_product_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  length;
    logic        in_valid;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        ready32, busy32, done32, ovf32, neg32;
    logic [31:0] result32;
    logic        ready8, busy8, done8, ovf8, neg8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;

    logic [31:0] va [256];
    logic [31:0] vb [256];

    typedef struct {
        int          len;
        int          a [3];
        int          b [3];
        bit          restart;
        logic [31:0] r32;
        logic        o32;
        logic [7:0]  r8;
        logic        o8;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    dot_product_sequencer #(.BIT_WIDTH(32), .LEN_WIDTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(ready32), .a_in(a_in), .b_in(b_in),
        .busy(busy32), .done(done32), .result(result32),
        .overflow(ovf32), .negative(neg32)
    );

    dot_product_sequencer #(.BIT_WIDTH(8), .LEN_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(ready8), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
        .busy(busy8), .done(done8), .result(result8),
        .overflow(ovf8), .negative(neg8)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Interpret the low w bits of v as a two's-complement number.
    function automatic longint to_signed(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    // Exact-arithmetic reference for one operation over va/vb at operand width w.
    function automatic void model(input int w, input int len, output logic [31:0] res, output logic ovf);
        longint acc;
        longint p;
        longint hi;
        longint lo;
        acc = 0;
        ovf = 1'b0;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        for (int i = 0; i < len; i++) begin
            p = to_signed(longint'(va[i]), w) * to_signed(longint'(vb[i]), w);
            if (p > hi || p < lo) ovf = 1'b1;
            acc = acc + to_signed(p, w);
            if (acc > hi || acc < lo) ovf = 1'b1;
            acc = to_signed(acc, w);
        end
        res = 32'(acc & ((longint'(1) <<< w) - 1));
    endfunction

    // One full operation: start, feed len pairs (optional idle lead-in, random bubbles,
    // optional ignored re-start), then check latency, results and return to IDLE.
    task automatic run_op(input string tag, input int len, input int pre_idle,
                          input int bubble_pct, input bit restart);
        int          idx;
        int          cyc;
        int          lat;
        bit          accepted;
        logic [31:0] exp32;
        logic [31:0] exp8;
        logic        eo32;
        logic        eo8;
        idx = 0;
        cyc = 0;
        lat = 0;
        model(32, len, exp32, eo32);
        model(8, len, exp8, eo8);

        start  = 1'b1;
        length = 8'(len);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_at_start"}, 32'(busy32), 32'd1);
        check({tag, " ready_at_start"}, 32'(ready32), 32'd1);

        while (idx < len && cyc < 2000) begin
            in_valid = (cyc >= pre_idle) && ($urandom_range(99) >= bubble_pct);
            a_in     = va[idx];
            b_in     = vb[idx];
            if (restart && cyc == 0) begin
                start  = 1'b1;
                length = 8'd5;
            end
            @(negedge clk);
            accepted = in_valid && ready32;
            @(posedge clk); #1;
            start = 1'b0;
            if (accepted) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " pairs_accepted"}, 32'(idx), 32'(len));

        do begin
            @(negedge clk);
            lat++;
            if (!done32) check({tag, " ready_after_last"}, 32'(ready32), 32'd0);
        end while (!done32 && lat < 8);

        check({tag, " done_latency"}, 32'(lat), 32'd2);
        check({tag, " done8"}, 32'(done8), 32'd1);
        check({tag, " result32"}, result32, exp32);
        check({tag, " overflow32"}, 32'(ovf32), 32'(eo32));
        check({tag, " negative32"}, 32'(neg32), 32'(exp32[31]));
        check({tag, " result8"}, 32'(result8), 32'(exp8[7:0]));
        check({tag, " overflow8"}, 32'(ovf8), 32'(eo8));
        check({tag, " negative8"}, 32'(neg8), 32'(exp8[7]));

        @(posedge clk); #1;
        check({tag, " busy_end"}, 32'(busy32), 32'd0);
        check({tag, " done_end"}, 32'(done32), 32'd0);
    endtask

    task automatic set_vec(input int i, input int len, input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2, input bit restart,
                           input logic [31:0] r32, input logic o32, input logic [7:0] r8, input logic o8);
        tbl[i].len     = len;
        tbl[i].a[0]    = a0;
        tbl[i].a[1]    = a1;
        tbl[i].a[2]    = a2;
        tbl[i].b[0]    = b0;
        tbl[i].b[1]    = b1;
        tbl[i].b[2]    = b2;
        tbl[i].restart = restart;
        tbl[i].r32     = r32;
        tbl[i].o32     = o32;
        tbl[i].r8      = r8;
        tbl[i].o8      = o8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_vec(0, 3,   1,   2, 3,  4, 5, 6, 1'b0, 32'd32,       1'b0, 8'h20, 1'b0);
        set_vec(1, 2,  -3,   2, 0,  5, 1, 0, 1'b0, 32'hFFFFFFF3, 1'b0, 8'hF3, 1'b0);
        set_vec(2, 2, 100, 100, 0,  1, 1, 0, 1'b0, 32'd200,      1'b0, 8'hC8, 1'b1);
        set_vec(3, 2,   5,  -6, 0,  7, 3, 0, 1'b1, 32'd17,       1'b0, 8'h11, 1'b0);

        rst_n    = 1'b1;
        start    = 1'b0;
        length   = 8'd0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", 32'(busy32), 32'd0);
        check("reset ready", 32'(ready32), 32'd0);
        check("reset done", 32'(done32), 32'd0);
        check("reset result", result32, 32'd0);
        check("reset overflow", 32'(ovf32), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < tbl[i].len; j++) begin
                va[j] = 32'(tbl[i].a[j]);
                vb[j] = 32'(tbl[i].b[j]);
            end
            run_op($sformatf("vec%0d", i), tbl[i].len, 0, 0, tbl[i].restart);
            check($sformatf("vec%0d hold result32", i), result32, tbl[i].r32);
            check($sformatf("vec%0d hold overflow32", i), 32'(ovf32), 32'(tbl[i].o32));
            check($sformatf("vec%0d hold result8", i), 32'(result8), 32'(tbl[i].r8));
            check($sformatf("vec%0d hold overflow8", i), 32'(ovf8), 32'(tbl[i].o8));
        end

        // Single pair that overflows only in the multiply at 8 bits.
        va[0] = 32'd16;
        vb[0] = 32'd16;
        run_op("mul_ovf", 1, 0, 0, 1'b0);
        check("mul_ovf result8", 32'(result8), 32'h00);
        check("mul_ovf overflow8", 32'(ovf8), 32'd1);
        check("mul_ovf result32", result32, 32'd256);

        // length == 0 finishes in one cycle with a cleared result.
        start  = 1'b1;
        length = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0 busy", 32'(busy32), 32'd1);
        check("len0 ready", 32'(ready32), 32'd0);
        @(negedge clk);
        check("len0 done", 32'(done32), 32'd1);
        check("len0 result32", result32, 32'd0);
        check("len0 overflow8", 32'(ovf8), 32'd0);
        @(posedge clk); #1;
        check("len0 busy_end", 32'(busy32), 32'd0);

        // Back-to-back start with three idle cycles before the only pair.
        va[0] = 32'd7;
        vb[0] = 32'd7;
        run_op("bubble", 1, 3, 0, 1'b0);
        check("bubble result32", result32, 32'd49);

        // Asynchronous reset in the middle of ACCEPT.
        va[0] = 32'd3; va[1] = 32'd4; va[2] = 32'd5;
        vb[0] = 32'd2; vb[1] = 32'd2; vb[2] = 32'd2;
        start  = 1'b1;
        length = 8'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = va[0];
        b_in     = vb[0];
        @(posedge clk); #1;
        a_in = va[1];
        b_in = vb[1];
        @(posedge clk); #1;
        check("midrst partial", result32, 32'd6);
        rst_n = 1'b0;
        #1;
        check("midrst result", result32, 32'd0);
        check("midrst ready", 32'(ready32), 32'd0);
        check("midrst busy", 32'(busy32), 32'd0);
        check("midrst done", 32'(done32), 32'd0);
        check("midrst overflow", 32'(ovf32), 32'd0);
        check("midrst negative", 32'(neg32), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // in_valid is still high here while idle and must not consume anything.
        run_op("after_rst", 3, 0, 0, 1'b0);
        check("after_rst result32", result32, 32'd24);

        for (int n = 0; n < 20; n++) begin
            int len;
            len = $urandom_range(12, 1);
            for (int j = 0; j < len; j++) begin
                if (n % 2 == 0) begin
                    va[j] = 32'($urandom_range(60)) - 32'd30;
                    vb[j] = 32'($urandom_range(60)) - 32'd30;
                end else begin
                    va[j] = $urandom;
                    vb[j] = $urandom;
                end
            end
            run_op($sformatf("rand%0d", n), len, 0, 30, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
